// File: rtl/conv_sequencer.sv
// conv_sequencer: sliding-window dot product over a snapshotted frame.
// A single DATA_W x DATA_W multiplier is time-shared across the taps. Each
// window result is presented on a valid/ready output before the next window
// is computed.
module conv_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TAPS    = 4,
  parameter int unsigned SAMPLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [TAPS*DATA_W-1:0]    weights,
  input  logic [SAMPLES*DATA_W-1:0] data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [17:0]               out_data,
  output logic [3:0]                out_index,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned KW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int unsigned PW = 2 * DATA_W;

  localparam logic [KW-1:0] LastK = KW'(TAPS - 1);
  localparam logic [IW-1:0] LastW = IW'(SAMPLES - TAPS);

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StEmit,
    StDone
  } state_e;

  state_e                    r_state, w_state_nxt;
  logic [TAPS*DATA_W-1:0]    r_weights, w_weights_nxt;
  logic [SAMPLES*DATA_W-1:0] r_data, w_data_nxt;
  logic [17:0]               r_acc, w_acc_nxt;
  logic [IW-1:0]             r_w, w_w_nxt;
  logic [KW-1:0]             r_k, w_k_nxt;
  logic [17:0]               r_out_data, w_out_data_nxt;
  logic [3:0]                r_out_index, w_out_index_nxt;

  logic [IW:0]               w_sidx;
  logic [DATA_W-1:0]         w_sample;
  logic [DATA_W-1:0]         w_tap;
  logic [PW-1:0]             w_prod;
  logic [17:0]               w_acc_sum;

  // Operand select and the shared multiplier for the current (w, k) step.
  always_comb begin
    w_sidx    = {1'b0, r_w} + (IW + 1)'(r_k);
    w_sample  = r_data[w_sidx * DATA_W +: DATA_W];
    w_tap     = r_weights[r_k * DATA_W +: DATA_W];
    w_prod    = w_sample * w_tap;
    w_acc_sum = r_acc + 18'(w_prod);
  end

  // Next-state and datapath updates; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_weights_nxt   = r_weights;
    w_data_nxt      = r_data;
    w_acc_nxt       = r_acc;
    w_w_nxt         = r_w;
    w_k_nxt         = r_k;
    w_out_data_nxt  = r_out_data;
    w_out_index_nxt = r_out_index;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_weights_nxt = weights;
          w_data_nxt    = data;
          w_acc_nxt     = '0;
          w_w_nxt       = '0;
          w_k_nxt       = '0;
          w_state_nxt   = StMac;
        end
      end
      StMac: begin
        w_acc_nxt = w_acc_sum;
        if (r_k == LastK) begin
          // Latch the finished sum so the output survives the acc clear.
          w_out_data_nxt  = w_acc_sum;
          w_out_index_nxt = 4'(r_w);
          w_state_nxt     = StEmit;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (r_w == LastW) begin
            w_state_nxt = StDone;
          end else begin
            w_w_nxt     = r_w + IW'(1);
            w_acc_nxt   = '0;
            w_k_nxt     = '0;
            w_state_nxt = StMac;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (abort && (r_state != StIdle)) begin
      w_state_nxt = StIdle;
      w_acc_nxt   = '0;
    end
  end

  // State and datapath registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_weights   <= '0;
      r_data      <= '0;
      r_acc       <= '0;
      r_w         <= '0;
      r_k         <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_weights   <= w_weights_nxt;
      r_data      <= w_data_nxt;
      r_acc       <= w_acc_nxt;
      r_w         <= w_w_nxt;
      r_k         <= w_k_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_index <= w_out_index_nxt;
    end
  end

  // Status outputs decode straight from the state so reset clears them at once.
  always_comb begin
    out_valid = (r_state == StEmit);
    busy      = (r_state != StIdle);
    done      = (r_state == StDone);
    out_data  = r_out_data;
    out_index = r_out_index;
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: scoreboard of expected window
// results, pushed at start and popped on each output handshake.
module tb_conv_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned NT = 4;
  localparam int unsigned NS = 16;
  localparam int unsigned NW = NS - NT + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic [NT*DW-1:0]  weights = '0;
  logic [NS*DW-1:0]  data = '0;
  logic              out_valid;
  logic [17:0]       out_data;
  logic [3:0]        out_index;
  logic              busy;
  logic              done;

  conv_sequencer #(
    .DATA_W (DW),
    .TAPS   (NT),
    .SAMPLES(NS)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .weights  (weights),
    .data     (data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_index(out_index),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [21:0] sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int frame_res = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_hs_cyc = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [17:0] conv_ref(input logic [NT*DW-1:0] wt,
                                           input logic [NS*DW-1:0] d, input int w);
    logic [17:0] s;
    s = '0;
    for (int k = 0; k < int'(NT); k++) begin
      s += 18'(d[(w + k) * DW +: DW]) * 18'(wt[k * DW +: DW]);
    end
    return s;
  endfunction

  // Cycle counter: cycle n is the interval after the n-th rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor on the falling edge: done pulses, latency, scoreboard pops.
  initial begin
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          frame_res++;
          last_hs_cyc = cyc;
          if (sb_q.size() == 0) begin
            check("sb_extra_result", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("out_index", 32'(out_index), 32'(e[21:18]));
            check("out_data", 32'(out_data), 32'(e[17:0]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic [NT*DW-1:0] wt, input logic [NS*DW-1:0] d);
    weights         = wt;
    data            = d;
    start           = 1'b1;
    start_cyc       = cyc;
    frame_res       = 0;
    first_valid_cyc = -1;
    for (int w = 0; w < int'(NW); w++) sb_q.push_back({4'(w), conv_ref(wt, d, w)});
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != d0) break;
      step();
    end
    if (done_cnt == d0) check("done_timeout", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic finish_frame(input int d0);
    wait_done(d0);
    repeat (3) step();
    check("result_count", 32'(frame_res), 32'(NW));
    check("sb_left", 32'(sb_q.size()), 32'd0);
    check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd5);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("done_cycle", 32'(last_done_cyc), 32'(last_hs_cyc + 1));
    check("idle_after_frame", 32'(busy), 32'd0);
  endtask

  function automatic logic [NS*DW-1:0] rand_data();
    logic [NS*DW-1:0] d;
    for (int i = 0; i < int'(NS); i++) d[i * DW +: DW] = 8'($urandom);
    return d;
  endfunction

  initial begin
    logic [NS*DW-1:0] ramp;
    logic [NS*DW-1:0] rd;
    logic [NT*DW-1:0] rw;
    int d0;

    for (int i = 0; i < int'(NS); i++) ramp[i * DW +: DW] = 8'(i);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    rst = 1'b0;
    step();
    check("idle_after_rst", 32'(busy), 32'd0);

    // Unit weights over a ramp: results 4w+6
    d0 = done_cnt;
    start_frame(32'h0101_0101, ramp);
    check("busy_in_frame", 32'(busy), 32'd1);
    finish_frame(d0);

    // Saturating operands: every result 0x3F804
    d0 = done_cnt;
    start_frame({NT{8'hFF}}, {NS{8'hFF}});
    finish_frame(d0);

    // Back-pressure at w=3 for 10 cycles
    d0 = done_cnt;
    rw = 32'($urandom);
    start_frame(rw, rand_data());
    for (int i = 0; i < 100; i++) begin
      if (frame_res == 3 && out_valid) break;
      step();
    end
    check("stall_reach_w3", 32'(frame_res), 32'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      if (sb_q.size() != 0) begin
        check("stall_index", 32'(out_index), 32'(sb_q[0][21:18]));
        check("stall_data", 32'(out_data), 32'(sb_q[0][17:0]));
      end
    end
    out_ready = 1'b1;
    finish_frame(d0);

    // Inputs changed and start re-pulsed mid-frame: snapshot must hold
    d0 = done_cnt;
    rw = 32'($urandom);
    rd = rand_data();
    start_frame(rw, rd);
    repeat (7) step();
    weights = '0;
    data    = '0;
    start   = 1'b1;
    step();
    start = 1'b0;
    finish_frame(d0);

    // Abort in MAC at w=5
    d0 = done_cnt;
    start_frame(32'h0102_0304, ramp);
    for (int i = 0; i < 100; i++) begin
      if (frame_res == 5) break;
      step();
    end
    check("abort_reach_w5", 32'(frame_res), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    repeat (5) step();
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_no_more_results", 32'(frame_res), 32'd5);

    d0 = done_cnt;
    start_frame(32'($urandom), rand_data());
    finish_frame(d0);

    // Reset during EMIT clears outputs without a clock edge
    d0 = done_cnt;
    out_ready = 1'b0;
    start_frame(32'($urandom), rand_data());
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step();
    end
    check("emit_reached", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_out_data", 32'(out_data), 32'd0);
    sb_q.delete();
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("rst_waits_for_start", 32'(busy), 32'd0);
    check("rst_no_done", 32'(done_cnt), 32'(d0));

    d0 = done_cnt;
    start_frame(32'h0101_0101, ramp);
    finish_frame(d0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
